// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, drives every datapath select/enable.
//
// Ports:
//   clk, rst (async active-low)
//   op, funct            : IR opcode / function fields
//   zero, overflow       : ALU flags
//   mem_ready            : shared memory finishes the current access
//   pcwrite .. alucontrol: datapath enables and selects
//   exc_ovf, exc_ill     : one-cycle exception pulses
//   state_dbg            : current state code
//   instr_count          : retired instruction counter
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             overflow,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             exc_ovf,
    output logic             exc_ill,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           r_state;
    logic             r_ovf_q;
    logic [CNT_W-1:0] r_cnt;

    logic       w_fn_ok;
    logic       w_fn_arith;
    logic [2:0] w_fn_alu;
    logic       w_op_ok;

    // funct field decode for R-type
    always_comb begin
        w_fn_ok    = 1'b1;
        w_fn_arith = 1'b0;
        w_fn_alu   = 3'b010;
        unique case (funct)
            6'b100000: begin w_fn_alu = 3'b010; w_fn_arith = 1'b1; end
            6'b100010: begin w_fn_alu = 3'b110; w_fn_arith = 1'b1; end
            6'b100100: w_fn_alu = 3'b000;
            6'b100101: w_fn_alu = 3'b001;
            6'b101010: w_fn_alu = 3'b111;
            default:   w_fn_ok = 1'b0;
        endcase
    end

    assign w_op_ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                     (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_ovf_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_FETCH: if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    unique case (op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (op == OP_SW)      r_state <= S_MEMWR;
                    else if (op == OP_LW) r_state <= S_MEMRD;
                    else                  r_state <= S_FETCH;
                end
                S_MEMRD: if (mem_ready) r_state <= S_MEMWB;
                S_MEMWR: begin
                    if (mem_ready) begin
                        r_state <= S_FETCH;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    r_ovf_q <= overflow & w_fn_arith;
                    r_state <= w_fn_ok ? S_ALUWB : S_FETCH;
                end
                S_ADDIEX: begin
                    r_ovf_q <= overflow;
                    r_state <= S_ADDIWB;
                end
                S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                    r_state <= S_FETCH;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    logic w_pcw, w_mrd, w_mwr, w_irw, w_rw, w_eo, w_ei;

    always_comb begin
        w_pcw      = 1'b0;
        w_mrd      = 1'b0;
        w_mwr      = 1'b0;
        w_irw      = 1'b0;
        w_rw       = 1'b0;
        w_eo       = 1'b0;
        w_ei       = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b010;
        unique case (r_state)
            S_FETCH: begin
                w_mrd   = 1'b1;
                alusrcb = 2'b01;
                w_irw   = mem_ready;
                w_pcw   = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                w_ei    = ~w_op_ok;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord  = 1'b1;
                w_mrd = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                w_rw     = 1'b1;
            end
            S_MEMWR: begin
                iord  = 1'b1;
                w_mwr = 1'b1;
            end
            S_EXEC: begin
                alusrca    = 1'b1;
                alucontrol = w_fn_alu;
                w_ei       = ~w_fn_ok;
            end
            S_ALUWB: begin
                regdst = 1'b1;
                w_rw   = ~r_ovf_q;
                w_eo   = r_ovf_q;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                w_pcw      = zero;
            end
            S_ADDIWB: begin
                w_rw = ~r_ovf_q;
                w_eo = r_ovf_q;
            end
            S_JUMP: begin
                pcsrc = 2'b10;
                w_pcw = 1'b1;
            end
            default: ;
        endcase
    end

    // enables are squashed for the whole time reset is held
    assign pcwrite     = w_pcw & rst;
    assign memread     = w_mrd & rst;
    assign memwrite    = w_mwr & rst;
    assign irwrite     = w_irw & rst;
    assign regwrite    = w_rw & rst;
    assign exc_ovf     = w_eo & rst;
    assign exc_ill     = w_ei & rst;
    assign state_dbg   = r_state;
    assign instr_count = r_cnt;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller.
// Builds per-cycle expectations per instruction and compares every cycle.
module tb_multicycle_controller;

    logic        clk;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        overflow;
    logic        mem_ready;
    logic        pcwrite, iord, memread, memwrite, irwrite;
    logic        regdst, memtoreg, regwrite, alusrca;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic        exc_ovf, exc_ill;
    logic [3:0]  state_dbg;
    logic [31:0] instr_count;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct),
        .zero(zero), .overflow(overflow), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .exc_ovf(exc_ovf), .exc_ill(exc_ill), .state_dbg(state_dbg),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mr, z, ov;
        logic [5:0] op, fn;
        logic [3:0] st;
        logic       pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        logic       eo, ei;
        bit         ret;
    } cyc_t;

    cyc_t        q[$];
    logic [5:0]  cur_op, cur_fn;
    logic [31:0] exp_cnt;
    int          n_pass, n_total;

    wire [21:0] dut_vec = {state_dbg, pcwrite, iord, memread, memwrite,
                           irwrite, regdst, memtoreg, regwrite, alusrca,
                           alusrcb, pcsrc, alucontrol, exc_ovf, exc_ill};

    function automatic logic [21:0] pack(cyc_t r);
        return {r.st, r.pcw, r.iord, r.mrd, r.mwr, r.irw, r.rdst, r.m2r,
                r.rw, r.asa, r.asb, r.pcs, r.alu, r.eo, r.ei};
    endfunction

    function automatic cyc_t base(logic [3:0] st);
        cyc_t r;
        r = '{default: '0};
        r.st  = st;
        r.alu = 3'b010;
        r.op  = cur_op;
        r.fn  = cur_fn;
        r.mr  = 1'b1;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else
            n_pass++;
    endtask

    // FETCH with w wait cycles
    task automatic fetch(int w);
        cyc_t r;
        repeat (w) begin
            r = base(4'd0);
            r.mr = 1'b0; r.mrd = 1'b1; r.asb = 2'b01;
            q.push_back(r);
        end
        r = base(4'd0);
        r.mrd = 1'b1; r.asb = 2'b01; r.irw = 1'b1; r.pcw = 1'b1;
        q.push_back(r);
    endtask

    task automatic decode();
        cyc_t r;
        r = base(4'd1);
        r.asb = 2'b11;
        r.ei = !(cur_op inside {6'b100011, 6'b101011, 6'b000000,
                                6'b000100, 6'b001000, 6'b000010});
        q.push_back(r);
    endtask

    task automatic memadr();
        cyc_t r;
        r = base(4'd2);
        r.asa = 1'b1; r.asb = 2'b10;
        q.push_back(r);
    endtask

    task automatic lw(int wf, int wm);
        cyc_t r;
        cur_op = 6'b100011;
        fetch(wf); decode(); memadr();
        for (int i = 0; i <= wm; i++) begin
            r = base(4'd3);
            r.mr = (i == wm); r.iord = 1'b1; r.mrd = 1'b1;
            q.push_back(r);
        end
        r = base(4'd4);
        r.m2r = 1'b1; r.rw = 1'b1; r.ret = 1'b1;
        q.push_back(r);
    endtask

    task automatic sw(int wf, int ww);
        cyc_t r;
        cur_op = 6'b101011;
        fetch(wf); decode(); memadr();
        for (int i = 0; i <= ww; i++) begin
            r = base(4'd5);
            r.mr = (i == ww); r.iord = 1'b1; r.mwr = 1'b1;
            r.ret = (i == ww);
            q.push_back(r);
        end
    endtask

    task automatic rtype(logic [5:0] fn, logic ov);
        cyc_t r;
        logic legal, arith;
        cur_op = 6'b000000; cur_fn = fn;
        fetch(0); decode();
        r = base(4'd6);
        r.asa = 1'b1; r.ov = ov;
        legal = 1'b1; arith = 1'b0;
        case (fn)
            6'b100000: begin r.alu = 3'b010; arith = 1'b1; end
            6'b100010: begin r.alu = 3'b110; arith = 1'b1; end
            6'b100100: r.alu = 3'b000;
            6'b100101: r.alu = 3'b001;
            6'b101010: r.alu = 3'b111;
            default:   legal = 1'b0;
        endcase
        r.ei = !legal;
        q.push_back(r);
        if (legal) begin
            r = base(4'd7);
            r.rdst = 1'b1;
            r.rw = !(ov && arith);
            r.eo = ov && arith;
            r.ret = 1'b1;
            q.push_back(r);
        end
    endtask

    task automatic beq(logic z);
        cyc_t r;
        cur_op = 6'b000100;
        fetch(0); decode();
        r = base(4'd8);
        r.asa = 1'b1; r.alu = 3'b110; r.pcs = 2'b01;
        r.z = z; r.pcw = z; r.ret = 1'b1;
        q.push_back(r);
    endtask

    task automatic addi(logic ov);
        cyc_t r;
        cur_op = 6'b001000;
        fetch(0); decode();
        r = base(4'd9);
        r.asa = 1'b1; r.asb = 2'b10; r.ov = ov;
        q.push_back(r);
        r = base(4'd10);
        r.rw = !ov; r.eo = ov; r.ret = 1'b1;
        q.push_back(r);
    endtask

    task automatic jmp(int wf);
        cyc_t r;
        cur_op = 6'b000010;
        fetch(wf); decode();
        r = base(4'd11);
        r.pcs = 2'b10; r.pcw = 1'b1; r.ret = 1'b1;
        q.push_back(r);
    endtask

    task automatic ill(logic [5:0] o);
        cur_op = o;
        fetch(0); decode();
    endtask

    // entered just after a rising edge; leaves just after a rising edge
    task automatic run();
        cyc_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            op = r.op; funct = r.fn; mem_ready = r.mr;
            zero = r.z; overflow = r.ov;
            @(negedge clk);
            chk($sformatf("outs st=%0d op=%b", r.st, r.op),
                64'(dut_vec), 64'(pack(r)));
            chk("instr_count", 64'(instr_count), 64'(exp_cnt));
            @(posedge clk); #1;
            if (r.ret) exp_cnt++;
        end
    endtask

    // FETCH selects with every enable squashed
    function automatic logic [21:0] rst_vec();
        cyc_t r;
        r = base(4'd0);
        r.asb = 2'b01;
        return pack(r);
    endfunction

    initial begin
        n_pass = 0; n_total = 0; exp_cnt = '0;
        cur_op = '0; cur_fn = '0;
        rst = 1'b0; op = '0; funct = '0;
        zero = 1'b0; overflow = 1'b0; mem_ready = 1'b0;
        #3;
        chk("reset outs", 64'(dut_vec), 64'(rst_vec()));
        chk("reset state", 64'(state_dbg), 64'd0);
        chk("reset count", 64'(instr_count), 64'd0);
        #9 rst = 1'b1;
        @(posedge clk); #1;

        lw(0, 0); run();
        chk("count after lw", 64'(instr_count), 64'd1);
        sw(0, 2); run();
        chk("count after sw", 64'(instr_count), 64'd2);
        beq(1'b1); beq(1'b0); run();
        rtype(6'b100000, 1'b1); rtype(6'b100101, 1'b1); run();
        chk("count after rtype", 64'(instr_count), 64'd6);
        ill(6'b111111); rtype(6'b000111, 1'b0); run();
        chk("count after illegal", 64'(instr_count), 64'd6);
        addi(1'b0); jmp(0); rtype(6'b100010, 1'b1);
        lw(1, 1); addi(1'b1); rtype(6'b101010, 1'b0);
        rtype(6'b100100, 1'b0); run();
        chk("count after mix", 64'(instr_count), 64'd13);

        // abandon a load while it waits in MEMRD
        cur_op = 6'b100011;
        fetch(0); decode(); memadr();
        begin
            cyc_t r;
            r = base(4'd3);
            r.mr = 1'b0; r.iord = 1'b1; r.mrd = 1'b1;
            q.push_back(r);
        end
        run();
        mem_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async reset outs", 64'(dut_vec), 64'(rst_vec()));
        chk("async reset count", 64'(instr_count), 64'd0);
        @(posedge clk); #1;
        chk("held reset outs", 64'(dut_vec), 64'(rst_vec()));
        exp_cnt = '0;
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        jmp(2); run();
        chk("count after restart", 64'(instr_count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
